regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (PW/RW/LE) between two writeback requesters: req0 = ALU writeback, req1 = load writeback.
- Each requester feeds a 1-entry holding slot, and a round-robin arbiter drains the slots into registered write-port outputs.
- Writes that target R15 go to the PC update path instead, because R15 in the register file is the external PROGCOUNT and cannot be written.
- Combinational hazard flags tell the decode stage when a read port address has a write still in flight.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 4, register address width.
- PC_IDX, 15, register index that is redirected to the PC path.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- REQ0_VALID  in  1  ALU writeback request.
- REQ0_READY  out  1  slot 0 can accept.
- REQ0_ADDR  in  ADDR_W  destination register.
- REQ0_DATA  in  DATA_W  write data.
- REQ1_VALID, REQ1_READY, REQ1_ADDR, REQ1_DATA: same as req0, for load writeback.
- PW  out  DATA_W  register file write data.
- RW  out  ADDR_W  register file write address.
- LE  out  1  register file load enable.
- PC_WE  out  1  one-cycle PC write strobe.
- PC_WDATA  out  DATA_W  new PC value.
- RA, RB, RC  in  ADDR_W  current read addresses.
- HAZ_A, HAZ_B, HAZ_C  out  1  a pending write targets RA/RB/RC.

Behaviour:
- Reset: while RST_N=0 at a rising edge, the following clear on that edge:
  - both slots empty; AGE=0; LAST=1.
  - PW=0, RW=0, LE=0, PC_WE=0, PC_WDATA=0.
- REQx_READY is 0 whenever RST_N=0. A request in flight during reset is dropped.
- Handshake:
  - A transfer occurs when REQx_VALID & REQx_READY at a rising edge. ADDR and DATA are captured into slot x.
  - REQx_READY = slot x empty OR slot x granted this cycle. This gives full throughput of 1 write per cycle per requester when uncontended.
  - The requester must hold VALID, ADDR and DATA stable until READY.
- Arbitration is combinational on slot state each cycle:
  - One slot occupied: that slot is granted.
  - Both occupied, different addresses: round-robin. Grant goes to the slot not equal to LAST. After reset, req0 wins the first tie.
  - Both occupied, same address: the older slot is granted, to preserve write order. AGE records which slot filled first. If both filled on the same edge, slot 0 is older. LAST is updated as usual.
  - No slot occupied: no grant.
- Output stage, registered, updated every rising edge:
  - Grant to a non-R15 address: PW=data, RW=addr, LE=1, PC_WE=0. The slot is cleared, unless it is refilled on the same edge.
  - Grant to address PC_IDX: PC_WE=1, PC_WDATA=data, LE=0. PW and RW hold their previous values.
  - No grant: LE=0, PC_WE=0, and PW/RW/PC_WDATA hold.
  - LE and PC_WE are single-cycle pulses per grant.
- Latency:
  - Request accepted at edge N drives LE/PC_WE high during cycle N+1 at the earliest.
  - The register file captures the data at edge N+2.
  - A losing slot waits one extra cycle per lost arbitration. The maximum added wait is 1 cycle.
- Hazard flags:
  - HAZ_A = (RA matches an occupied slot address) OR (LE=1 and RW==RA).
  - HAZ_B and HAZ_C are defined the same way for RB and RC.
  - RA/RB/RC==PC_IDX never flags.
- Simultaneous drain and refill of the same slot on one edge is legal. The new entry becomes the youngest, and AGE is updated accordingly.
- All address and data widths are fixed. No arithmetic is performed on data.

Test Plan:
- Reset check: hold RST_N=0 for 2 cycles with REQ0_VALID=1 -> READY=0, LE=0, PC_WE=0, PW=0. After release, first accept occurs on the next edge.
- Single write: req0 writes R3=0xDEADBEEF -> one cycle later LE=1, RW=3, PW=0xDEADBEEF for exactly 1 cycle. HAZ_A=1 with RA=3 from accept until LE drops.
- Contention: both requesters issue back-to-back streams (req0 to R1,R2; req1 to R4,R5) -> grant order R1,R4,R2,R5. LE is high 4 consecutive cycles.
- Same-address ordering: req1 writes R7=0x11, then one cycle later req0 writes R7=0x22 while req1's slot is still blocked -> 0x11 is written before 0x22.
- PC redirect: req1 writes R15=0x00000040 -> PC_WE=1 and PC_WDATA=0x40 for 1 cycle. LE stays 0 and HAZ_x stays 0 for address 15.
- Reset mid-operation: both slots full, assert RST_N=0 for 1 edge -> slots empty. No LE pulse follows; the dropped writes never appear.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU and load writeback through two
// 1-entry slots and a round-robin arbiter; writes to the PC index go to the PC path.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int PC_IDX = 15
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0_VALID,
  output logic              REQ0_READY,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  input  logic              REQ1_VALID,
  output logic              REQ1_READY,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic [DATA_W-1:0] PW,
  output logic [ADDR_W-1:0] RW,
  output logic              LE,
  output logic              PC_WE,
  output logic [DATA_W-1:0] PC_WDATA,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RC,
  output logic              HAZ_A,
  output logic              HAZ_B,
  output logic              HAZ_C
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

  logic              slot0_v, slot1_v;
  logic [ADDR_W-1:0] slot0_addr, slot1_addr;
  logic [DATA_W-1:0] slot0_data, slot1_data;
  logic              age;   // index of the slot that filled first
  logic              last;  // index of the most recently granted slot

  logic              gnt0, gnt1, gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;
  logic              acc0, acc1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (slot0_v && slot1_v) begin
      // Same destination must drain oldest-first so the final register value is right.
      if (slot0_addr == slot1_addr) begin
        gnt0 = ~age;
        gnt1 = age;
      end else begin
        gnt0 = last;
        gnt1 = ~last;
      end
    end else begin
      gnt0 = slot0_v;
      gnt1 = slot1_v;
    end
    gnt_any  = gnt0 | gnt1;
    gnt_addr = gnt1 ? slot1_addr : slot0_addr;
    gnt_data = gnt1 ? slot1_data : slot0_data;
  end

  assign REQ0_READY = RST_N & (~slot0_v | gnt0);
  assign REQ1_READY = RST_N & (~slot1_v | gnt1);
  assign acc0       = REQ0_VALID & REQ0_READY;
  assign acc1       = REQ1_VALID & REQ1_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      slot0_v    <= 1'b0;
      slot1_v    <= 1'b0;
      slot0_addr <= '0;
      slot1_addr <= '0;
      slot0_data <= '0;
      slot1_data <= '0;
      age        <= 1'b0;
      last       <= 1'b1;
      PW         <= '0;
      RW         <= '0;
      LE         <= 1'b0;
      PC_WE      <= 1'b0;
      PC_WDATA   <= '0;
    end else begin
      if (acc0) begin
        slot0_v    <= 1'b1;
        slot0_addr <= REQ0_ADDR;
        slot0_data <= REQ0_DATA;
      end else if (gnt0) begin
        slot0_v <= 1'b0;
      end

      if (acc1) begin
        slot1_v    <= 1'b1;
        slot1_addr <= REQ1_ADDR;
        slot1_data <= REQ1_DATA;
      end else if (gnt1) begin
        slot1_v <= 1'b0;
      end

      // A new entry is younger than whatever survives in the other slot.
      if (acc0 && acc1) begin
        age <= 1'b0;
      end else if (acc0) begin
        age <= (slot1_v && !gnt1) ? 1'b1 : 1'b0;
      end else if (acc1) begin
        age <= (slot0_v && !gnt0) ? 1'b0 : 1'b1;
      end

      if (gnt_any) begin
        last <= gnt1;
      end

      LE    <= 1'b0;
      PC_WE <= 1'b0;
      if (gnt_any) begin
        if (gnt_addr == PC_ADDR) begin
          PC_WE    <= 1'b1;
          PC_WDATA <= gnt_data;
        end else begin
          LE <= 1'b1;
          PW <= gnt_data;
          RW <= gnt_addr;
        end
      end
    end
  end

  function automatic logic pending_hit(input logic [ADDR_W-1:0] r);
    pending_hit = (r != PC_ADDR) &&
                  ((slot0_v && (slot0_addr == r)) ||
                   (slot1_v && (slot1_addr == r)) ||
                   (LE && (RW == r)));
  endfunction

  assign HAZ_A = pending_hit(RA);
  assign HAZ_B = pending_hit(RB);
  assign HAZ_C = pending_hit(RC);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic
// checked against a slot/sequence-number reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic [31:0] pw, pc_wdata;
  logic [3:0]  rw, ra, rb, rc;
  logic        le, pc_we, haz_a, haz_b, haz_c;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0_VALID(req0_valid), .REQ0_READY(req0_ready), .REQ0_ADDR(req0_addr), .REQ0_DATA(req0_data),
    .REQ1_VALID(req1_valid), .REQ1_READY(req1_ready), .REQ1_ADDR(req1_addr), .REQ1_DATA(req1_data),
    .PW(pw), .RW(rw), .LE(le), .PC_WE(pc_we), .PC_WDATA(pc_wdata),
    .RA(ra), .RB(rb), .RC(rc), .HAZ_A(haz_a), .HAZ_B(haz_b), .HAZ_C(haz_c)
  );

  // Reference model: each slot holds an entry tagged with a global fill sequence number.
  bit          mv[2];
  logic [3:0]  ma[2];
  logic [31:0] md[2];
  int          mseq[2];
  int          m_last;
  int          seq_ctr = 0;
  logic [31:0] e_pw, e_pcwd;
  logic [3:0]  e_rw;
  logic        e_le, e_pcwe;
  bit          m_acc0, m_acc1;
  int          cyc = 0;

  typedef struct {logic [3:0] a; logic [31:0] d; int c;} wr_t;
  wr_t         obs[$];
  logic [31:0] obs_pc[$];

  function automatic int m_grant();
    if (mv[0] && mv[1]) begin
      if (ma[0] == ma[1]) return (mseq[0] < mseq[1]) ? 0 : 1;
      return (m_last == 0) ? 1 : 0;
    end
    if (mv[0]) return 0;
    if (mv[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(int x);
    return (rst_n === 1'b1) && (!mv[x] || m_grant() == x);
  endfunction

  function automatic bit m_haz(logic [3:0] r);
    if (r == 4'd15) return 1'b0;
    return (mv[0] && ma[0] == r) || (mv[1] && ma[1] == r) || (e_le && e_rw == r);
  endfunction

  task automatic m_clear();
    mv[0] = 0; mv[1] = 0; m_last = 1;
    e_pw = 0; e_rw = 0; e_le = 0; e_pcwe = 0; e_pcwd = 0;
  endtask

  task automatic tick();
    int g;
    bit r_rst;
    logic [3:0] a0, a1;
    logic [31:0] d0, d1;
    r_rst = rst_n;
    a0 = req0_addr; a1 = req1_addr; d0 = req0_data; d1 = req1_data;
    g = m_grant();
    m_acc0 = req0_valid && m_ready(0);
    m_acc1 = req1_valid && m_ready(1);
    @(posedge clk);
    if (!r_rst) begin
      m_clear();
      m_acc0 = 0; m_acc1 = 0;
    end else begin
      e_le = 0; e_pcwe = 0;
      if (g >= 0) begin
        if (ma[g] == 4'd15) begin e_pcwe = 1; e_pcwd = md[g]; end
        else begin e_le = 1; e_pw = md[g]; e_rw = ma[g]; end
        mv[g] = 0;
        m_last = g;
      end
      if (m_acc0) begin mv[0] = 1; ma[0] = a0; md[0] = d0; mseq[0] = seq_ctr++; end
      if (m_acc1) begin mv[1] = 1; ma[1] = a1; md[1] = d1; mseq[1] = seq_ctr++; end
    end
    @(negedge clk);
    cyc++;
    if (le === 1'b1) obs.push_back('{rw, pw, cyc});
    if (pc_we === 1'b1) obs_pc.push_back(pc_wdata);
  endtask

  task automatic reset_dut();
    rst_n = 0; req0_valid = 0; req1_valid = 0;
    tick();
    rst_n = 1;
    obs.delete(); obs_pc.delete();
  endtask

  task automatic test_reset();
    rst_n = 0; req0_valid = 1; req0_addr = 4'd2; req0_data = 32'h1234; req1_valid = 0;
    req1_addr = 0; req1_data = 0; ra = 4'd2; rb = 0; rc = 0;
    tick(); tick();
    #1;
    n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0 got=%0b exp=0", req0_ready); end
    n_vec++; if (le !== 1'b0) begin n_err++; $display("FAIL reset_le got=%0b exp=0", le); end
    n_vec++; if (pc_we !== 1'b0) begin n_err++; $display("FAIL reset_pc_we got=%0b exp=0", pc_we); end
    n_vec++; if (pw !== 32'h0) begin n_err++; $display("FAIL reset_pw got=%h exp=0", pw); end
    rst_n = 1; #1;
    n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL release_ready0 got=%0b exp=1", req0_ready); end
    tick();
    req0_valid = 0; #1;
    n_vec++; if (haz_a !== 1'b1) begin n_err++; $display("FAIL release_haz_a got=%0b exp=1", haz_a); end
    tick(); #1;
    n_vec++; if (le !== 1'b1 || rw !== 4'd2 || pw !== 32'h1234) begin n_err++; $display("FAIL release_write got le=%0b rw=%0d pw=%h exp le=1 rw=2 pw=1234", le, rw, pw); end
    tick();
  endtask

  task automatic test_single_write();
    ra = 4'd3;
    req0_valid = 1; req0_addr = 4'd3; req0_data = 32'hDEADBEEF; #1;
    n_vec++; if (haz_a !== 1'b0) begin n_err++; $display("FAIL single_haz_pre got=%0b exp=0", haz_a); end
    tick();
    req0_valid = 0; #1;
    n_vec++; if (le !== 1'b0 || haz_a !== 1'b1) begin n_err++; $display("FAIL single_accept got le=%0b haz_a=%0b exp le=0 haz_a=1", le, haz_a); end
    tick(); #1;
    n_vec++; if (le !== 1'b1 || rw !== 4'd3 || pw !== 32'hDEADBEEF || haz_a !== 1'b1) begin n_err++; $display("FAIL single_write got le=%0b rw=%0d pw=%h haz_a=%0b exp 1/3/deadbeef/1", le, rw, pw, haz_a); end
    tick(); #1;
    n_vec++; if (le !== 1'b0 || haz_a !== 1'b0) begin n_err++; $display("FAIL single_after got le=%0b haz_a=%0b exp 0/0", le, haz_a); end
  endtask

  task automatic test_contention();
    logic [3:0] a0[2], a1[2], exp_a[4];
    int i0, i1;
    a0 = '{4'd1, 4'd2}; a1 = '{4'd4, 4'd5}; exp_a = '{4'd1, 4'd4, 4'd2, 4'd5};
    reset_dut();
    i0 = 0; i1 = 0;
    for (int c = 0; c < 10; c++) begin
      req0_valid = (i0 < 2); req0_addr = a0[i0 % 2]; req0_data = 32'h100 + 32'(a0[i0 % 2]);
      req1_valid = (i1 < 2); req1_addr = a1[i1 % 2]; req1_data = 32'h100 + 32'(a1[i1 % 2]);
      #1;
      tick();
      if (m_acc0) i0++;
      if (m_acc1) i1++;
    end
    req0_valid = 0; req1_valid = 0;
    n_vec++; if (obs.size() !== 4) begin n_err++; $display("FAIL contention_count got=%0d exp=4", obs.size()); end
    for (int k = 0; k < 4; k++) begin
      if (k < obs.size()) begin
        n_vec++;
        if (obs[k].a !== exp_a[k] || obs[k].d !== 32'h100 + 32'(exp_a[k])) begin
          n_err++; $display("FAIL contention_order[%0d] got R%0d=%h exp R%0d", k, obs[k].a, obs[k].d, exp_a[k]);
        end
      end
    end
    if (obs.size() == 4) begin
      n_vec++; if (obs[3].c - obs[0].c !== 3) begin n_err++; $display("FAIL contention_consecutive got span=%0d exp=3", obs[3].c - obs[0].c); end
    end
  endtask

  task automatic test_same_addr();
    reset_dut();
    req0_valid = 1; req0_addr = 4'd2; req0_data = 32'h0A;
    req1_valid = 1; req1_addr = 4'd7; req1_data = 32'h11;
    tick();
    req1_valid = 0; req0_addr = 4'd7; req0_data = 32'h22;
    tick();
    req0_valid = 0;
    for (int c = 0; c < 4; c++) tick();
    n_vec++;
    if (obs.size() !== 3) begin n_err++; $display("FAIL same_addr_count got=%0d exp=3", obs.size()); end
    else if (obs[0].a !== 4'd2 || obs[1].a !== 4'd7 || obs[1].d !== 32'h11 || obs[2].a !== 4'd7 || obs[2].d !== 32'h22) begin
      n_err++; $display("FAIL same_addr_order got R%0d=%h R%0d=%h R%0d=%h exp R2=0a R7=11 R7=22", obs[0].a, obs[0].d, obs[1].a, obs[1].d, obs[2].a, obs[2].d);
    end
    // Both fill on one edge with the same destination: slot 0 counts as older.
    obs.delete();
    rb = 4'd9;
    req0_valid = 1; req0_addr = 4'd9; req0_data = 32'h91;
    req1_valid = 1; req1_addr = 4'd9; req1_data = 32'h92;
    tick();
    req0_valid = 0; req1_valid = 0; #1;
    n_vec++; if (haz_b !== 1'b1) begin n_err++; $display("FAIL same_edge_haz_b got=%0b exp=1", haz_b); end
    for (int c = 0; c < 4; c++) tick();
    n_vec++;
    if (obs.size() !== 2) begin n_err++; $display("FAIL same_edge_count got=%0d exp=2", obs.size()); end
    else if (obs[0].d !== 32'h91 || obs[1].d !== 32'h92) begin
      n_err++; $display("FAIL same_edge_order got %h,%h exp 91,92", obs[0].d, obs[1].d);
    end
  endtask

  task automatic test_pc_redirect();
    ra = 4'd15; rb = 4'd15; rc = 4'd15;
    req1_valid = 1; req1_addr = 4'd15; req1_data = 32'h40;
    tick();
    req1_valid = 0; #1;
    n_vec++; if ({haz_a, haz_b, haz_c} !== 3'b000) begin n_err++; $display("FAIL pc_haz got=%b exp=000", {haz_a, haz_b, haz_c}); end
    n_vec++; if (le !== 1'b0 || pc_we !== 1'b0) begin n_err++; $display("FAIL pc_accept got le=%0b pc_we=%0b exp 0/0", le, pc_we); end
    tick(); #1;
    n_vec++; if (pc_we !== 1'b1 || pc_wdata !== 32'h40 || le !== 1'b0) begin n_err++; $display("FAIL pc_write got pc_we=%0b pc_wdata=%h le=%0b exp 1/40/0", pc_we, pc_wdata, le); end
    n_vec++; if (rw !== 4'd9 || pw !== 32'h92) begin n_err++; $display("FAIL pc_hold got rw=%0d pw=%h exp 9/92", rw, pw); end
    n_vec++; if ({haz_a, haz_b, haz_c} !== 3'b000) begin n_err++; $display("FAIL pc_haz_write got=%b exp=000", {haz_a, haz_b, haz_c}); end
    tick(); #1;
    n_vec++; if (pc_we !== 1'b0) begin n_err++; $display("FAIL pc_pulse got=%0b exp=0", pc_we); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    ra = 4'd1; rb = 4'd2; rc = 4'd0;
    req0_valid = 1; req0_addr = 4'd1; req0_data = 32'hAA;
    req1_valid = 1; req1_addr = 4'd2; req1_data = 32'hBB;
    tick();
    rst_n = 0; req0_valid = 0; req1_valid = 0; #1;
    n_vec++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready got %0b%0b exp 00", req0_ready, req1_ready); end
    n_vec++; if (haz_a !== 1'b1 || haz_b !== 1'b1) begin n_err++; $display("FAIL mid_full_haz got %0b%0b exp 11", haz_a, haz_b); end
    tick();
    rst_n = 1; #1;
    n_vec++; if (haz_a !== 1'b0 || haz_b !== 1'b0 || req0_ready !== 1'b1) begin n_err++; $display("FAIL mid_cleared got haz=%0b%0b ready0=%0b exp 00/1", haz_a, haz_b, req0_ready); end
    for (int c = 0; c < 3; c++) tick();
    n_vec++; if (obs.size() !== 0 || obs_pc.size() !== 0) begin n_err++; $display("FAIL mid_dropped got writes=%0d pc=%0d exp 0/0", obs.size(), obs_pc.size()); end
  endtask

  function automatic logic [3:0] rand_addr();
    return ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic test_random();
    bit h0, h1;
    int rate;
    reset_dut();
    h0 = 0; h1 = 0;
    for (int c = 0; c < 800; c++) begin
      rate = (c < 400) ? 40 : 90;
      if (!h0) begin req0_valid = ($urandom_range(0, 99) < rate); req0_addr = rand_addr(); req0_data = $urandom; end
      if (!h1) begin req1_valid = ($urandom_range(0, 99) < rate); req1_addr = rand_addr(); req1_data = $urandom; end
      ra = rand_addr(); rb = rand_addr(); rc = rand_addr();
      rst_n = ($urandom_range(0, 99) != 0);
      #1;
      n_vec++; if (req0_ready !== m_ready(0)) begin n_err++; if (n_err < 20) $display("FAIL rnd_ready0 cyc=%0d got=%0b exp=%0b", cyc, req0_ready, m_ready(0)); end
      n_vec++; if (req1_ready !== m_ready(1)) begin n_err++; if (n_err < 20) $display("FAIL rnd_ready1 cyc=%0d got=%0b exp=%0b", cyc, req1_ready, m_ready(1)); end
      n_vec++; if (le !== e_le || pc_we !== e_pcwe) begin n_err++; if (n_err < 20) $display("FAIL rnd_strobes cyc=%0d got le=%0b pc_we=%0b exp %0b/%0b", cyc, le, pc_we, e_le, e_pcwe); end
      n_vec++; if (pw !== e_pw || rw !== e_rw) begin n_err++; if (n_err < 20) $display("FAIL rnd_port cyc=%0d got rw=%0d pw=%h exp rw=%0d pw=%h", cyc, rw, pw, e_rw, e_pw); end
      n_vec++; if (pc_wdata !== e_pcwd) begin n_err++; if (n_err < 20) $display("FAIL rnd_pc_wdata cyc=%0d got=%h exp=%h", cyc, pc_wdata, e_pcwd); end
      n_vec++; if ({haz_a, haz_b, haz_c} !== {m_haz(ra), m_haz(rb), m_haz(rc)}) begin n_err++; if (n_err < 20) $display("FAIL rnd_haz cyc=%0d got=%b exp=%b", cyc, {haz_a, haz_b, haz_c}, {m_haz(ra), m_haz(rb), m_haz(rc)}); end
      tick();
      h0 = req0_valid && !m_acc0;
      h1 = req1_valid && !m_acc1;
    end
    rst_n = 1; req0_valid = 0; req1_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr();
    test_pc_redirect();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
